systolic_mult_ctrl: RTL and testbench
=====================================

Name: systolic_mult_ctrl

Overview:
Sequencer for a bit-serial systolic multiplier array, a chain of WIDTH multiplier cells with cell 0 at the output end.
- Accepts operand pairs on a valid/ready handshake.
- Flushes stale carries out of the array, then streams the multiplier LSB-first into the array while holding the multiplicand on the cell weight inputs.
- Collects the serial product bits from cell 0 and presents the 2*WIDTH-bit product on a valid/ready handshake.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits.
ARRAY_LAT, 2, cycles from driving serial bit k on o_SERIAL_IN to product bit k appearing on i_ARRAY_OUT (minimum 1).

Ports:
i_CLK  input  1  system clock; all state changes on the rising edge.
i_RST_N  input  1  asynchronous active-low reset.
i_A  input  WIDTH  multiplicand; sampled on accept.
i_B  input  WIDTH  multiplier; sampled on accept.
i_VALID  input  1  operand pair valid.
o_READY  output  1  controller can accept an operand pair.
o_WEIGHT  output  WIDTH  to array weight inputs; bit i drives cell i.
o_SERIAL_IN  output  1  serial bit into the input end of the array.
i_ARRAY_OUT  input  1  serial product bit from cell 0.
o_PRODUCT  output  2*WIDTH  result; stable while o_VALID=1.
o_VALID  output  1  product valid.
i_READY  input  1  consumer accepts the product.
o_BUSY  output  1  high in FLUSH, SHIFT or DONE.

Behaviour:
- Reset (asynchronous, i_RST_N=0), effective immediately:
  - State IDLE; counter = 0.
  - o_READY=1; o_VALID=0; o_BUSY=0.
  - o_WEIGHT=0; o_SERIAL_IN=0; o_PRODUCT=0.
  - Operand registers cleared.
  - Reset mid-operation abandons the operation; no product is emitted.
- States are IDLE, FLUSH, SHIFT and DONE.
- IDLE:
  - o_READY=1; o_WEIGHT=0; o_SERIAL_IN=0.
  - Accept occurs when i_VALID && o_READY: latch i_A and i_B, clear the counter, go to FLUSH.
- FLUSH:
  - Runs 2*WIDTH cycles with o_WEIGHT=0 and o_SERIAL_IN=0 to clear the array's internal carries and pipeline (the cells have no reset).
  - The counter counts 0..2*WIDTH-1, then clears; go to SHIFT.
- SHIFT:
  - Runs 2*WIDTH+ARRAY_LAT cycles (counter c = 0..2*WIDTH+ARRAY_LAT-1) with o_WEIGHT = latched A.
  - o_SERIAL_IN = B[c] for c < WIDTH, else 0.
  - For c >= ARRAY_LAT, sample i_ARRAY_OUT into product bit (c-ARRAY_LAT), via a right-shifting 2*WIDTH-bit register.
  - After the last count, load o_PRODUCT and go to DONE.
- DONE:
  - o_VALID=1; o_PRODUCT holds.
  - On i_VALID-independent i_READY=1, o_VALID drops next edge; go to IDLE.
  - i_READY held low stalls indefinitely with the product stable.
- o_READY is 1 only in IDLE. No accept is possible while busy; an input held valid waits.
- Latency: o_VALID rises exactly 4*WIDTH+ARRAY_LAT cycles after the accept edge (34 for 8/2). Back-to-back throughput is one product per 4*WIDTH+ARRAY_LAT+2 cycles.
- Arithmetic: unsigned. The product is taken verbatim from the array; the controller performs no arithmetic on the data.
- Counter width is $clog2(2*WIDTH+ARRAY_LAT+1); it never wraps within a state.

Optional Feature:
SYSTOLIC_MULT_CTRL_ABORT_EN:
- When defined, adds input i_ABORT (1 bit).
- i_ABORT=1 in SHIFT: discard partial product, clear the counter, go to FLUSH. After FLUSH completes, go to IDLE (not SHIFT). No o_VALID is produced.
- i_ABORT=1 in DONE: drop o_VALID next edge, go to IDLE.
- Ignored in IDLE and FLUSH.
- When undefined, the port does not exist and behaviour is as above.

Test Plan:
- Bench setup: WIDTH=8, ARRAY_LAT=2; the bench array is a real cell chain or a cycle-accurate model.
- A=13, B=11, i_READY=1 -> o_VALID after 34 cycles; o_PRODUCT=143; o_READY=1 the cycle after handshake.
- A=255, B=255 -> 65025. Then A=0, B=200 -> 0. Then A=1, B=1 -> 1, back-to-back with i_VALID held high; each accepted only in IDLE.
- A=200, B=3 with i_READY=0 for 20 cycles after o_VALID -> o_PRODUCT=600 held stable, o_READY=0 throughout; IDLE one cycle after i_READY=1.
- Pre-load the array model with random carries, then A=7, B=9 -> 63; the flush makes stale state irrelevant.
- Assert i_RST_N=0 at SHIFT count 5 of A=99, B=77 -> outputs at reset values immediately; next op A=5, B=6 -> 30. With ABORT_EN: i_ABORT at SHIFT count 3 -> no o_VALID, IDLE after 16 flush cycles.

Source files
------------

// File: rtl/systolic_mult_ctrl.sv
// Sequencer for a bit-serial systolic multiplier array: flush, stream B LSB-first, collect product.
// Optional abort input enabled by defining SYSTOLIC_MULT_CTRL_ABORT_EN.
module systolic_mult_ctrl #(
  parameter int WIDTH     = 8,
  parameter int ARRAY_LAT = 2
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic [WIDTH-1:0]   i_A,
  input  logic [WIDTH-1:0]   i_B,
  input  logic               i_VALID,
  output logic               o_READY,
  output logic [WIDTH-1:0]   o_WEIGHT,
  output logic               o_SERIAL_IN,
  input  logic               i_ARRAY_OUT,
  output logic [2*WIDTH-1:0] o_PRODUCT,
  output logic               o_VALID,
  input  logic               i_READY,
  output logic               o_BUSY
`ifdef SYSTOLIC_MULT_CTRL_ABORT_EN
  ,
  input  logic               i_ABORT
`endif
);

  localparam int PW      = 2 * WIDTH;
  localparam int SHIFT_N = PW + ARRAY_LAT;
  localparam int CW      = $clog2(SHIFT_N + 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(PW - 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(SHIFT_N - 1);
  localparam logic [CW-1:0] LAT_C      = CW'(ARRAY_LAT);

  typedef enum logic [1:0] {IDLE, FLUSH, SHIFT, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [PW-1:0]     sr_q;
  logic              aborted_q;
  logic              abort;

`ifdef SYSTOLIC_MULT_CTRL_ABORT_EN
  assign abort = i_ABORT;
`else
  assign abort = 1'b0;
`endif

  // b_q is consumed as a shift register during SHIFT, so the serial bit is
  // always its LSB and zeros follow once the multiplier is exhausted.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state       <= IDLE;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sr_q        <= '0;
      aborted_q   <= 1'b0;
      o_READY     <= 1'b1;
      o_VALID     <= 1'b0;
      o_BUSY      <= 1'b0;
      o_WEIGHT    <= '0;
      o_SERIAL_IN <= 1'b0;
      o_PRODUCT   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_VALID && o_READY) begin
            a_q       <= i_A;
            b_q       <= i_B;
            cnt       <= '0;
            aborted_q <= 1'b0;
            o_READY   <= 1'b0;
            o_BUSY    <= 1'b1;
            state     <= FLUSH;
          end
        end
        FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            cnt <= '0;
            if (aborted_q) begin
              aborted_q <= 1'b0;
              o_READY   <= 1'b1;
              o_BUSY    <= 1'b0;
              state     <= IDLE;
            end else begin
              o_WEIGHT    <= a_q;
              o_SERIAL_IN <= b_q[0];
              b_q         <= b_q >> 1;
              sr_q        <= '0;
              state       <= SHIFT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            cnt         <= '0;
            aborted_q   <= 1'b1;
            sr_q        <= '0;
            o_WEIGHT    <= '0;
            o_SERIAL_IN <= 1'b0;
            state       <= FLUSH;
          end else begin
            o_SERIAL_IN <= b_q[0];
            b_q         <= b_q >> 1;
            if (cnt >= LAT_C)
              sr_q <= {i_ARRAY_OUT, sr_q[PW-1:1]};
            if (cnt == SHIFT_LAST) begin
              o_PRODUCT   <= {i_ARRAY_OUT, sr_q[PW-1:1]};
              o_VALID     <= 1'b1;
              o_WEIGHT    <= '0;
              o_SERIAL_IN <= 1'b0;
              cnt         <= '0;
              state       <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (i_READY || abort) begin
            o_VALID <= 1'b0;
            o_READY <= 1'b1;
            o_BUSY  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_mult_ctrl.sv
// Scoreboard bench for systolic_mult_ctrl driving a cycle-accurate serial-parallel array model.
module tb_systolic_mult_ctrl;
  localparam int WIDTH     = 8;
  localparam int ARRAY_LAT = 2;
  localparam int LAT       = 4 * WIDTH + ARRAY_LAT;

  logic               i_CLK = 1'b0;
  logic               i_RST_N = 1'b0;
  logic [WIDTH-1:0]   i_A = '0;
  logic [WIDTH-1:0]   i_B = '0;
  logic               i_VALID = 1'b0;
  logic               o_READY;
  logic [WIDTH-1:0]   o_WEIGHT;
  logic               o_SERIAL_IN;
  logic               i_ARRAY_OUT;
  logic [2*WIDTH-1:0] o_PRODUCT;
  logic               o_VALID;
  logic               i_READY = 1'b1;
  logic               o_BUSY;
`ifdef SYSTOLIC_MULT_CTRL_ABORT_EN
  logic               i_ABORT = 1'b0;
`endif

  systolic_mult_ctrl #(.WIDTH(WIDTH), .ARRAY_LAT(ARRAY_LAT)) dut (
    .i_CLK(i_CLK), .i_RST_N(i_RST_N), .i_A(i_A), .i_B(i_B), .i_VALID(i_VALID),
    .o_READY(o_READY), .o_WEIGHT(o_WEIGHT), .o_SERIAL_IN(o_SERIAL_IN),
    .i_ARRAY_OUT(i_ARRAY_OUT), .o_PRODUCT(o_PRODUCT), .o_VALID(o_VALID),
    .i_READY(i_READY), .o_BUSY(o_BUSY)
`ifdef SYSTOLIC_MULT_CTRL_ABORT_EN
    , .i_ABORT(i_ABORT)
`endif
  );

  always #5 i_CLK = ~i_CLK;

  // Array model: partial-sum register plus a delay line of ARRAY_LAT stages, no reset.
  logic [WIDTH-1:0]     cell_p = '0;
  logic [ARRAY_LAT-1:0] dly = '0;
  logic [WIDTH:0]       t_sum;
  logic                 load_stale = 1'b0;
  logic [WIDTH-1:0]     stale_p = 8'hA5;
  logic [ARRAY_LAT-1:0] stale_d = '1;

  always @(posedge i_CLK) begin
    if (load_stale) begin
      cell_p <= stale_p;
      dly    <= stale_d;
    end else begin
      t_sum  = {1'b0, cell_p} + (o_SERIAL_IN ? {1'b0, o_WEIGHT} : '0);
      cell_p <= t_sum[WIDTH:1];
      dly    <= {dly[ARRAY_LAT-2:0], t_sum[0]};
    end
  end
  assign i_ARRAY_OUT = dly[ARRAY_LAT-1];

  int tests = 0;
  int fails = 0;
  logic [2*WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: compares every product handshake against the scoreboard.
  always @(negedge i_CLK) begin
    if (i_RST_N && o_VALID && i_READY) begin
      if (exp_q.size() == 0) check("unexpected_product", o_PRODUCT, 32'hFFFF_FFFF);
      else check("product", o_PRODUCT, exp_q.pop_front());
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit push,
                      input bit hold, output time t_acc);
    int n;
    @(negedge i_CLK);
    i_A = a; i_B = b; i_VALID = 1'b1;
    n = 0;
    while (!o_READY && n < 200) begin @(negedge i_CLK); n++; end
    if (!o_READY) check("accept_timeout", 0, 1);
    @(posedge i_CLK);
    t_acc = $time;
    if (push) exp_q.push_back(16'(a) * 16'(b));
    #1;
    if (!hold) i_VALID = 1'b0;
  endtask

  task automatic wait_valid(input logic [7:0] a, input logic [7:0] b, output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge i_CLK); #1; cyc++;
      if (cyc == 1) begin check("busy_in_flush", o_BUSY, 1); check("ready_low_busy", o_READY, 0); end
      if (cyc == 5) check("weight_zero_flush", o_WEIGHT, 0);
      if (cyc == 16) check("serial_b0", o_SERIAL_IN, b[0]);
      if (cyc == 18) check("serial_b2", o_SERIAL_IN, b[2]);
      if (cyc == 20) check("weight_a_shift", o_WEIGHT, a);
      if (o_VALID) break;
    end
  endtask

  initial begin
    time t1, t2;
    int lat, n;
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t1, t2;
    int lat, n, bad;
    #12;
    check("rst_ready", o_READY, 1);
    check("rst_valid", o_VALID, 0);
    check("rst_busy", o_BUSY, 0);
    check("rst_weight", o_WEIGHT, 0);
    check("rst_serial", o_SERIAL_IN, 0);
    check("rst_product", o_PRODUCT, 0);
    @(negedge i_CLK); i_RST_N = 1'b1;

    // Basic operation and latency
    send(13, 11, 1, 0, t1);
    wait_valid(13, 11, lat);
    check("latency_13x11", lat, LAT);
    @(posedge i_CLK); #1;
    check("ready_after_hs", o_READY, 1);
    check("valid_drop_after_hs", o_VALID, 0);

    // Back-to-back with i_VALID held high
    send(255, 255, 1, 1, t1);
    wait_valid(255, 255, lat);
    check("latency_255x255", lat, LAT);
    send(0, 200, 1, 1, t2);
    check("throughput_cycles", 32'((t2 - t1) / 10), LAT + 2);
    wait_valid(0, 200, lat);
    send(1, 1, 1, 0, t1);
    check("throughput_cycles2", 32'((t1 - t2) / 10), LAT + 2);
    wait_valid(1, 1, lat);
    check("latency_1x1", lat, LAT);

    // Consumer stall
    @(posedge i_CLK); #1; i_READY = 1'b0;
    send(200, 3, 1, 0, t1);
    wait_valid(200, 3, lat);
    check("latency_stall", lat, LAT);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_CLK);
      if (o_PRODUCT !== 16'd600 || o_VALID !== 1'b1 || o_READY !== 1'b0) bad++;
    end
    check("stall_stable", bad, 0);
    @(posedge i_CLK); #1; i_READY = 1'b1;
    @(posedge i_CLK); #1;
    check("idle_after_stall", o_READY, 1);

    // Stale array state
    load_stale = 1'b1;
    @(posedge i_CLK); #1; load_stale = 1'b0;
    send(7, 9, 1, 0, t1);
    wait_valid(7, 9, lat);
    check("latency_stale", lat, LAT);

    // Reset in the middle of SHIFT
    @(posedge i_CLK); #1;
    send(99, 77, 0, 0, t1);
    repeat (21) @(posedge i_CLK);
    #1; i_RST_N = 1'b0; #1;
    check("midrst_ready", o_READY, 1);
    check("midrst_busy", o_BUSY, 0);
    check("midrst_weight", o_WEIGHT, 0);
    check("midrst_serial", o_SERIAL_IN, 0);
    check("midrst_product", o_PRODUCT, 0);
    @(negedge i_CLK); i_RST_N = 1'b1;
    send(5, 6, 1, 0, t1);
    wait_valid(5, 6, lat);
    check("latency_after_rst", lat, LAT);
    @(posedge i_CLK); #1;

`ifdef SYSTOLIC_MULT_CTRL_ABORT_EN
    send(50, 60, 0, 0, t1);
    repeat (19) @(posedge i_CLK);
    #1; i_ABORT = 1'b1;
    @(posedge i_CLK); #1; i_ABORT = 1'b0;
    n = 0;
    while (!o_READY && n < 40) begin @(posedge i_CLK); #1; n++; end
    check("abort_flush_cycles", n, 2 * WIDTH);
    check("abort_no_valid", o_VALID, 0);
    i_READY = 1'b0;
    send(2, 3, 0, 0, t1);
    wait_valid(2, 3, lat);
    check("abort_done_product", o_PRODUCT, 6);
    i_ABORT = 1'b1;
    @(posedge i_CLK); #1; i_ABORT = 1'b0;
    check("abort_done_valid", o_VALID, 0);
    check("abort_done_ready", o_READY, 1);
    i_READY = 1'b1;
`endif

    repeat (4) @(posedge i_CLK);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
